// File: rtl/rns_pkg.sv
// Package: rns_pkg
// Shared constants, types and elaboration-time helpers for the RNS decoder.
//   RNS_W          residue width
//   RNS_M0..RNS_M3 default moduli (pairwise coprime, product <= 2^32)
//   rns4_t         four packed residues, index k holds residue k
//   mrc_state_t    decoder FSM states
//   inv_mod(a, m)  modular inverse of a mod m (extended Euclid), for constants only
package rns_pkg;

  localparam int unsigned RNS_W  = 8;
  localparam int unsigned RNS_M0 = 233;
  localparam int unsigned RNS_M1 = 239;
  localparam int unsigned RNS_M2 = 241;
  localparam int unsigned RNS_M3 = 251;

  typedef logic [3:0][RNS_W-1:0] rns4_t;

  typedef enum logic [1:0] {
    IDLE,
    MRC,
    HORNER,
    DONE
  } mrc_state_t;

  // Extended Euclid. Only called with coprime constant operands, so the
  // inverse always exists; a negative coefficient is folded back into [0,m).
  function automatic int inv_mod(input int a, input int m);
    int t;
    int new_t;
    int r;
    int new_r;
    int q;
    int tmp;
    t     = 0;
    new_t = 1;
    r     = m;
    new_r = a % m;
    while (new_r != 0) begin
      q     = r / new_r;
      tmp   = t - q * new_t;
      t     = new_t;
      new_t = tmp;
      tmp   = r - q * new_r;
      r     = new_r;
      new_r = tmp;
    end
    if (t < 0) t = t + m;
    return t;
  endfunction

endpackage

// File: rtl/rns_mod_mulsub.sv
// Module: rns_mod_mulsub
// Combinational modular multiply-subtract: res = ((a - b) mod m) * c mod m.
//   a, b   in  W  residues, both already < m
//   c      in  W  constant multiplier (an inverse from the MRC table)
//   m_sel  in  2  modulus select: 0 -> M1, 1 -> M2, 2/3 -> M3
//   res    out W  result, < m
module rns_mod_mulsub
  import rns_pkg::*;
#(
  parameter int unsigned W  = RNS_W,
  parameter int unsigned M1 = RNS_M1,
  parameter int unsigned M2 = RNS_M2,
  parameter int unsigned M3 = RNS_M3
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [1:0]   m_sel,
  output logic [W-1:0] res
);

  logic [W-1:0]   m;
  logic [W-1:0]   diff;
  logic [2*W-1:0] prod;

  // When a < b the W-bit subtraction wraps; adding m in the same width
  // wraps it back, leaving a - b + m which is already below m.
  always_comb begin
    case (m_sel)
      2'd0:    m = W'(M1);
      2'd1:    m = W'(M2);
      default: m = W'(M3);
    endcase
    if (a >= b) diff = a - b;
    else        diff = a - b + m;
    prod = {{W{1'b0}}, diff} * {{W{1'b0}}, c};
  end

  // One constant-divisor reduction per modulus, then a select, so each
  // remainder stays a fixed-constant operator.
  always_comb begin
    case (m_sel)
      2'd0:    res = W'(prod % (2*W)'(M1));
      2'd1:    res = W'(prod % (2*W)'(M2));
      default: res = W'(prod % (2*W)'(M3));
    endcase
  end

endmodule

// File: rtl/rns_to_int_mrc.sv
// Module: rns_to_int_mrc
// Sequential RNS-to-integer decoder: mixed-radix conversion over 6 cycles,
// Horner evaluation over 3 cycles, result published one cycle later.
//   clk       in   1    system clock
//   reset     in   1    asynchronous, active-low reset
//   in_valid  in   1    x_rns valid this cycle
//   in_ready  out  1    idle, a word is accepted on in_valid
//   x_rns     in   4W   packed residues {r3,r2,r1,r0}
//   done      out  1    one-cycle pulse, y/err updated
//   busy      out  1    conversion in progress
//   y         out  32   reconstructed integer in [0, M0*M1*M2*M3)
//   err       out  1    some input residue was >= its modulus (y forced 0)
module rns_to_int_mrc
  import rns_pkg::*;
#(
  parameter int unsigned M0 = RNS_M0,
  parameter int unsigned M1 = RNS_M1,
  parameter int unsigned M2 = RNS_M2,
  parameter int unsigned M3 = RNS_M3,
  parameter int unsigned W  = RNS_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4*W-1:0] x_rns,
  output logic          done,
  output logic          busy,
  output logic [31:0]   y,
  output logic          err
);

  if ((64'(M0) * 64'(M1) * 64'(M2) * 64'(M3) > 64'h1_0000_0000) ||
      (M0 >= (1 << W)) || (M1 >= (1 << W)) ||
      (M2 >= (1 << W)) || (M3 >= (1 << W))) begin : g_bad_moduli
    $error("rns_to_int_mrc: moduli do not fit W bits or their product exceeds 2^32");
  end

  localparam logic [W-1:0] MODS [4] = '{W'(M0), W'(M1), W'(M2), W'(M3)};

  // INVij = Mi^-1 mod Mj, fixed at elaboration
  localparam logic [W-1:0] INV01 = W'(inv_mod(int'(M0), int'(M1)));
  localparam logic [W-1:0] INV02 = W'(inv_mod(int'(M0), int'(M2)));
  localparam logic [W-1:0] INV03 = W'(inv_mod(int'(M0), int'(M3)));
  localparam logic [W-1:0] INV12 = W'(inv_mod(int'(M1), int'(M2)));
  localparam logic [W-1:0] INV13 = W'(inv_mod(int'(M1), int'(M3)));
  localparam logic [W-1:0] INV23 = W'(inv_mod(int'(M2), int'(M3)));

  mrc_state_t          state_q;
  mrc_state_t          state_d;
  logic [2:0]          step_q;
  logic [3:0][W-1:0]   rr;
  logic [31:0]         acc;
  logic                err_lat;

  logic [3:0][W-1:0]   red;
  logic [3:0]          bad;
  logic [1:0]          i_idx;
  logic [1:0]          j_idx;
  logic [W-1:0]        inv_c;
  logic [W-1:0]        ms_res;
  logic [W-1:0]        h_digit;
  logic [31:0]         h_mult;
  logic [31:0]         acc_next;

  // Entry reduction: raw residues are < 2^W < 2*Mk, so a single
  // conditional subtract brings them into range and flags the error.
  always_comb begin
    red = '0;
    bad = '0;
    for (int k = 0; k < 4; k++) begin
      if (x_rns[k*W +: W] >= MODS[k]) begin
        red[k] = x_rns[k*W +: W] - MODS[k];
        bad[k] = 1'b1;
      end else begin
        red[k] = x_rns[k*W +: W];
      end
    end
  end

  // MRC pair schedule (i,j): (0,1),(0,2),(0,3),(1,2),(1,3),(2,3)
  always_comb begin
    i_idx = 2'd0;
    j_idx = 2'd1;
    inv_c = INV01;
    case (step_q)
      3'd0: begin i_idx = 2'd0; j_idx = 2'd1; inv_c = INV01; end
      3'd1: begin i_idx = 2'd0; j_idx = 2'd2; inv_c = INV02; end
      3'd2: begin i_idx = 2'd0; j_idx = 2'd3; inv_c = INV03; end
      3'd3: begin i_idx = 2'd1; j_idx = 2'd2; inv_c = INV12; end
      3'd4: begin i_idx = 2'd1; j_idx = 2'd3; inv_c = INV13; end
      default: begin i_idx = 2'd2; j_idx = 2'd3; inv_c = INV23; end
    endcase
  end

  rns_mod_mulsub #(
    .W  (W),
    .M1 (M1),
    .M2 (M2),
    .M3 (M3)
  ) u_mulsub (
    .a     (rr[j_idx]),
    .b     (rr[i_idx]),
    .c     (inv_c),
    .m_sel (j_idx - 2'd1),
    .res   (ms_res)
  );

  // Horner digit/radix for the current step; acc < M keeps this in 32 bits
  always_comb begin
    h_digit = rr[0];
    h_mult  = 32'(M0);
    case (step_q)
      3'd0:    begin h_digit = rr[2]; h_mult = 32'(M2); end
      3'd1:    begin h_digit = rr[1]; h_mult = 32'(M1); end
      default: begin h_digit = rr[0]; h_mult = 32'(M0); end
    endcase
    acc_next = 32'(h_digit) + h_mult * acc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = MRC;
      end
      MRC:     if (step_q == 3'd5) state_d = HORNER;
      HORNER:  if (step_q == 3'd2) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The last MRC step produces a3, which seeds the accumulator directly so
  // HORNER needs only the three multiply-add steps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_q  <= '0;
      rr      <= '0;
      acc     <= '0;
      err_lat <= 1'b0;
      y       <= '0;
      err     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            rr      <= red;
            err_lat <= |bad;
            step_q  <= '0;
          end
        end
        MRC: begin
          rr[j_idx] <= ms_res;
          if (step_q == 3'd5) begin
            acc    <= 32'(ms_res);
            step_q <= '0;
          end else begin
            step_q <= step_q + 3'd1;
          end
        end
        HORNER: begin
          acc <= acc_next;
          if (step_q == 3'd2) step_q <= '0;
          else                step_q <= step_q + 3'd1;
        end
        DONE: begin
          y    <= err_lat ? 32'd0 : acc;
          err  <= err_lat;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
